spike_out_collector: RTL and testbench
======================================

Name: spike_out_collector

Overview:
- Output-side counterpart of the packet loader. It sits on packet_out/packet_out_valid of RANCNetworkGrid_3x2.
- Per tick window, it decodes 8-bit output packets into a NUM_OUTPUT-bit spike vector.
- It discards the first LAYER_DELAY windows, which carry network pipeline latency, then commits one vector per picture into an internal result memory.
- A host or bench reads the memory after done; this replaces bench-side spike logging and the output file dump.

Parameters:
- NUM_OUTPUT, 250: spike vector width; valid packet indices are 0..NUM_OUTPUT-1.
- NUM_PICTURE, 3: number of vectors stored before done.
- LAYER_DELAY, 1: number of closed windows discarded before the first store.
- ADDR_W, 2: result memory address width. Must satisfy 2^ADDR_W >= NUM_PICTURE.
- CNT_W, 16: width of the window and picture counters.

Ports:
- clk, input, 1: clock, rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- start, input, 1: single-cycle pulse that arms collection.
- tick, input, 1: network tick; opens a new window.
- packet_out, input, 8: spike neuron index from the grid.
- packet_out_valid, input, 1: qualifies packet_out.
- rd_en, input, 1: read request.
- rd_addr, input, ADDR_W: picture index to read.
- rd_data, output, NUM_OUTPUT: stored spike vector.
- rd_valid, output, 1: rd_data valid, one cycle after rd_en.
- num_stored, output, CNT_W: vectors committed so far.
- busy, output, 1: state is ARMED or COLLECT.
- done, output, 1: NUM_PICTURE vectors committed.
- range_error, output, 1: sticky; a valid packet_out was >= NUM_OUTPUT.

Behaviour:
- Reset values: rd_data=0, rd_valid=0, num_stored=0, busy=0, done=0, range_error=0, accumulator=0, window counter=0, state=IDLE. Memory contents are undefined after reset.
- Reset is asynchronous and may occur mid-operation. The collector returns to IDLE; a new start is then required.
- States:
  - IDLE: start -> ARMED and clear num_stored, window counter, accumulator and range_error.
  - ARMED: waits for the first tick. Packets in this state are ignored. The first tick -> COLLECT and opens window 0 with accumulator=0.
  - COLLECT: on each tick the current window w closes.
    - If w >= LAYER_DELAY, store the accumulator at address w-LAYER_DELAY and increment num_stored.
    - The window counter then increments and the accumulator reloads (see the coincident-tick rule below).
    - When num_stored reaches NUM_PICTURE -> DONE and done=1 from the following cycle.
  - DONE: holds. start -> ARMED with the same clearing as IDLE, and done drops the next cycle.
- start in ARMED or COLLECT is ignored.
- Packet decode applies in COLLECT only. On packet_out_valid with packet_out < NUM_OUTPUT, set accumulator bit [NUM_OUTPUT-1-packet_out]. Bit order is MSB = neuron 0, matching the software simulator file.
- Duplicate packets are idempotent.
- A valid packet with packet_out >= NUM_OUTPUT sets range_error and does not touch the accumulator.
- Tick coincident with packet_out_valid: the stored vector excludes that packet. The accumulator reloads to 0 with that packet's bit set, so the packet belongs to the new window.
- packet_out_valid in IDLE, ARMED or DONE is ignored and is not range checked.
- Read port:
  - Synchronous. rd_en in cycle N gives rd_data and rd_valid=1 in cycle N+1; rd_valid=0 otherwise.
  - rd_data holds its last value when rd_en=0.
  - rd_addr >= NUM_PICTURE returns all zeros.
  - Reads are allowed in any state. A read of the address being written in the same cycle returns the old contents.
- Counters do not wrap: NUM_PICTURE+LAYER_DELAY must be < 2^CNT_W.

Test Plan:
- Single picture, LAYER_DELAY=1, NUM_PICTURE=1:
  - Stimulus: start; tick; tick; packets 0, 5, 249; tick.
  - Required: done=1; num_stored=1; read addr 0 gives bits 249, 244, 0 set, all others 0.
- Three pictures, LAYER_DELAY=1:
  - Stimulus: packets {3}, {7, 7}, {200} in windows 1..3, followed by the closing ticks.
  - Required: addr0 bit 246 set; addr1 bit 242 set; addr2 bit 49 set; done after the 4th tick.
- Coincident tick and valid:
  - Stimulus: packet 10 in the same cycle as the tick that closes window 1.
  - Required: addr0 excludes bit 239; addr1 contains bit 239.
- Range error:
  - Stimulus: valid packet_out=250 in COLLECT.
  - Required: range_error=1 and stays 1; stored vector unaffected. A restart via start clears range_error.
- Reset mid-COLLECT:
  - Stimulus: assert reset_n=0 after 2 stores.
  - Required: all outputs take their reset values immediately. Ticks without start store nothing.
- Read port edges:
  - rd_en with rd_addr=3 -> rd_data=0, rd_valid=1 one cycle later.
  - start pulse while busy=1 -> no effect.

Source files
------------

// File: rtl/spike_out_collector.sv
// spike_out_collector: decodes grid output packets into per-window spike
// vectors and commits one vector per picture into a small result memory.
module spike_out_collector #(
   parameter int NUM_OUTPUT  = 250,
   parameter int NUM_PICTURE = 3,
   parameter int LAYER_DELAY = 1,
   parameter int ADDR_W      = 2,
   parameter int CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  tick,
   input  logic [7:0]            packet_out,
   input  logic                  packet_out_valid,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [NUM_OUTPUT-1:0] rd_data,
   output logic                  rd_valid,
   output logic [CNT_W-1:0]      num_stored,
   output logic                  busy,
   output logic                  done,
   output logic                  range_error
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_COLLECT,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LD_C = CNT_W'(LAYER_DELAY);
   localparam logic [CNT_W-1:0] NP_C = CNT_W'(NUM_PICTURE);
   localparam logic [ADDR_W:0] NP_A = (ADDR_W+1)'(NUM_PICTURE);
   localparam logic [8:0] NO_C = 9'(NUM_OUTPUT);
   localparam logic [NUM_OUTPUT-1:0] MSB_1 =
      {1'b1, {(NUM_OUTPUT-1){1'b0}}};

   state_t state, state_d;

   logic [NUM_OUTPUT-1:0] acc;
   logic [NUM_OUTPUT-1:0] pkt_vec;
   logic [NUM_OUTPUT-1:0] mem [2**ADDR_W];
   logic [CNT_W-1:0]      win_cnt;
   logic [ADDR_W-1:0]     wr_addr;
   logic                  pkt_ok;
   logic                  pkt_bad;
   logic                  clr;
   logic                  open_win;
   logic                  close_win;
   logic                  in_collect;
   logic                  store;

   // Neuron 0 maps to the MSB, matching the software simulator dump.
   assign pkt_ok  = packet_out_valid && ({1'b0, packet_out} < NO_C);
   assign pkt_bad = packet_out_valid && !({1'b0, packet_out} < NO_C);
   assign pkt_vec = pkt_ok ? (MSB_1 >> packet_out) : '0;

   // The first LAYER_DELAY windows only carry pipeline latency.
   assign store   = close_win && (win_cnt >= LD_C);
   assign wr_addr = ADDR_W'(win_cnt - LD_C);

   assign busy = (state == S_ARMED) || (state == S_COLLECT);
   assign done = (state == S_DONE);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_d;
   end

   // Next-state and window control decode.
   always_comb begin
      state_d    = state;
      clr        = 1'b0;
      open_win   = 1'b0;
      close_win  = 1'b0;
      in_collect = 1'b0;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_ARMED;
               clr     = 1'b1;
            end
         end
         S_ARMED: begin
            if (tick) begin
               state_d  = S_COLLECT;
               open_win = 1'b1;
            end
         end
         S_COLLECT: begin
            in_collect = 1'b1;
            if (tick) begin
               close_win = 1'b1;
               if ((win_cnt >= LD_C) &&
                   ((num_stored + CNT_W'(1)) == NP_C))
                  state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Accumulator, counters and sticky range flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc         <= '0;
         win_cnt     <= '0;
         num_stored  <= '0;
         range_error <= 1'b0;
      end else if (clr) begin
         acc         <= '0;
         win_cnt     <= '0;
         num_stored  <= '0;
         range_error <= 1'b0;
      end else begin
         if (open_win) begin
            acc     <= '0;
            win_cnt <= '0;
         end
         if (close_win) begin
            acc     <= pkt_vec;
            win_cnt <= win_cnt + CNT_W'(1);
            if (store) num_stored <= num_stored + CNT_W'(1);
         end else if (in_collect) begin
            acc <= acc | pkt_vec;
         end
         if (in_collect && pkt_bad) range_error <= 1'b1;
      end
   end

   // Result memory write; contents are not reset.
   always_ff @(posedge clk) begin
      if (store) mem[wr_addr] <= acc;
   end

   // Registered read port; same-cycle write returns old contents.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en)
            rd_data <= ({1'b0, rd_addr} < NP_A) ? mem[rd_addr] : '0;
      end
   end

endmodule

// File: tb/tb_spike_out_collector.sv
// tb_spike_out_collector: randomized windows against a window-list model,
// read results checked by a queue-driven monitor.
module tb_spike_out_collector;

   localparam int NO = 250;
   localparam int NP = 3;
   localparam int LD = 1;
   localparam int AW = 2;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          tick = 1'b0;
   logic [7:0]    packet_out = '0;
   logic          packet_out_valid = 1'b0;
   logic          rd_en = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic [NO-1:0] rd_data;
   logic          rd_valid;
   logic [CW-1:0] num_stored;
   logic          busy;
   logic          done;
   logic          range_error;

   int checks = 0;
   int failures = 0;

   logic [NO-1:0] exp_q [$];
   logic          rd_en_q = 1'b0;
   logic [NO-1:0] prev_pic [NP];
   bit            have_prev = 0;

   always #5 clk = ~clk;

   spike_out_collector #(
      .NUM_OUTPUT(NO), .NUM_PICTURE(NP), .LAYER_DELAY(LD),
      .ADDR_W(AW), .CNT_W(CW)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .start(start),
      .tick(tick),
      .packet_out(packet_out),
      .packet_out_valid(packet_out_valid),
      .rd_en(rd_en),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .rd_valid(rd_valid),
      .num_stored(num_stored),
      .busy(busy),
      .done(done),
      .range_error(range_error)
   );

   task automatic chk_v(string nm, logic [NO-1:0] act,
                        logic [NO-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_b(string nm, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chk_n(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [NO-1:0] bitv(int p);
      logic [NO-1:0] v;
      v = '0;
      v[NO-1-p] = 1'b1;
      return v;
   endfunction

   always @(posedge clk) rd_en_q <= rd_en;

   // Monitor: every valid read response pops one scoreboard entry.
   always @(negedge clk) begin
      if (reset_n) begin
         chk_b("rd_valid_timing", rd_valid, rd_en_q);
         if (rd_valid) begin
            if (exp_q.size() == 0)
               chk_b("rd_unexpected", rd_valid, 1'b0);
            else
               chk_v("rd_data", rd_data, exp_q.pop_front());
         end
      end
   end

   task automatic cyc(bit t = 0, bit v = 0, logic [7:0] p = '0,
                      bit s = 0, bit re = 0, logic [AW-1:0] ra = '0,
                      logic [NO-1:0] rexp = '0);
      tick = t;
      packet_out_valid = v;
      packet_out = p;
      start = s;
      rd_en = re;
      rd_addr = ra;
      if (re) exp_q.push_back(rexp);
      @(posedge clk);
      #1;
      tick = 1'b0;
      packet_out_valid = 1'b0;
      start = 1'b0;
      rd_en = 1'b0;
   endtask

   function automatic logic [NO-1:0] rd_exp(int a);
      if (a >= NP) return '0;
      return prev_pic[a];
   endfunction

   task automatic read_all_random(int n);
      int a;
      logic [NO-1:0] last;
      last = '0;
      for (int i = 0; i < n; i++) begin
         a = $urandom_range(0, 3);
         last = rd_exp(a);
         cyc(0, 0, '0, 0, 1, AW'(a), last);
      end
      cyc();
      cyc();
      chk_v("rd_data_hold", rd_data, last);
   endtask

   task automatic run_random();
      logic [NO-1:0] ew [NP+LD+1];
      bit            oor;
      bit            c;
      bit            last;
      int            n;
      logic [7:0]    p;
      oor = 0;
      foreach (ew[i]) ew[i] = '0;
      if (!busy) cyc(0, 0, '0, 1);
      chk_b("rnd_busy_armed", busy, 1'b1);
      chk_n("rnd_stored_clr", int'(num_stored), 0);
      repeat ($urandom_range(0, 3)) cyc(0, 1, 8'($urandom));
      cyc(1, 1'($urandom_range(0, 1)), 8'($urandom));
      chk_b("rnd_armed_noerr", range_error, 1'b0);
      for (int w = 0; w < NP + LD; w++) begin
         n = $urandom_range(0, 5);
         repeat (n) begin
            if ($urandom_range(0, 2) == 0) cyc();
            if ($urandom_range(0, 7) == 0)
               p = 8'($urandom_range(250, 255));
            else
               p = 8'($urandom_range(0, 249));
            if (p >= NO) oor = 1;
            else ew[w] |= bitv(p);
            cyc(0, 1, p);
         end
         c = ($urandom_range(0, 2) == 0);
         p = 8'($urandom_range(0, 252));
         if (c) begin
            if (p >= NO) oor = 1;
            else ew[w+1] |= bitv(p);
         end
         last = (w == NP + LD - 1);
         cyc(1, c, p, 0, last && have_prev, AW'(NP-1),
             prev_pic[NP-1]);
         chk_n("rnd_num_stored", int'(num_stored),
               (w + 1 > LD) ? (w + 1 - LD) : 0);
         chk_b("rnd_done", done, last);
      end
      chk_b("rnd_range_error", range_error, oor);
      chk_b("rnd_busy_done", busy, 1'b0);
      repeat (2) cyc(0, 1, 8'($urandom));
      chk_n("rnd_done_hold", int'(num_stored), NP);
      for (int a = 0; a < NP; a++) prev_pic[a] = ew[a+LD];
      have_prev = 1;
      read_all_random(6);
   endtask

   task automatic reset_test();
      logic [NO-1:0] ew [LD+2];
      logic [7:0]    p;
      foreach (ew[i]) ew[i] = '0;
      if (!busy) cyc(0, 0, '0, 1);
      cyc(1);
      for (int w = 0; w < LD + 2; w++) begin
         p = 8'($urandom_range(0, 249));
         ew[w] |= bitv(p);
         cyc(0, 1, p);
         cyc(1);
      end
      chk_n("rst_pre_stored", int'(num_stored), 2);
      cyc(0, 1, 8'd251);
      chk_b("rst_pre_rerr", range_error, 1'b1);
      cyc(0, 0, '0, 0, 1, '0, ew[LD]);
      cyc();
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk_v("rst_rd_data", rd_data, '0);
      chk_b("rst_rd_valid", rd_valid, 1'b0);
      chk_n("rst_num_stored", int'(num_stored), 0);
      chk_b("rst_busy", busy, 1'b0);
      chk_b("rst_done", done, 1'b0);
      chk_b("rst_range_error", range_error, 1'b0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (4) begin
         cyc(0, 1, 8'($urandom_range(0, 249)));
         cyc(1);
      end
      chk_n("rst_no_store", int'(num_stored), 0);
      chk_b("rst_idle_busy", busy, 1'b0);
      chk_b("rst_idle_done", done, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_v("reset_rd_data", rd_data, '0);
      chk_b("reset_rd_valid", rd_valid, 1'b0);
      chk_n("reset_num_stored", int'(num_stored), 0);
      chk_b("reset_busy", busy, 1'b0);
      chk_b("reset_done", done, 1'b0);
      chk_b("reset_range_error", range_error, 1'b0);
      reset_n = 1'b1;
      cyc();
      cyc(1, 1, 8'd9);
      chk_b("idle_tick_busy", busy, 1'b0);

      cyc(0, 0, '0, 1);
      chk_b("dir_busy", busy, 1'b1);
      cyc(0, 1, 8'd20);
      cyc(1);
      cyc(0, 1, 8'd100);
      cyc(1);
      chk_n("dir_stored_w0", int'(num_stored), 0);
      cyc(0, 1, 8'd3);
      cyc(1, 1, 8'd10);
      chk_n("dir_stored_w1", int'(num_stored), 1);
      cyc(0, 1, 8'd7);
      cyc(0, 1, 8'd7);
      cyc(0, 1, 8'd250);
      chk_b("dir_range_error", range_error, 1'b1);
      cyc(0, 0, '0, 1);
      chk_b("dir_start_busy", busy, 1'b1);
      chk_n("dir_start_stored", int'(num_stored), 1);
      cyc(1);
      chk_n("dir_stored_w2", int'(num_stored), 2);
      chk_b("dir_not_done", done, 1'b0);
      cyc(0, 1, 8'd200);
      cyc(1);
      chk_b("dir_done", done, 1'b1);
      chk_n("dir_stored_w3", int'(num_stored), 3);
      chk_b("dir_busy_off", busy, 1'b0);
      prev_pic[0] = bitv(3);
      prev_pic[1] = bitv(7) | bitv(10);
      prev_pic[2] = bitv(200);
      have_prev = 1;
      cyc(0, 1, 8'd255);
      for (int a = 0; a < 4; a++)
         cyc(0, 0, '0, 0, 1, AW'(a), rd_exp(a));
      cyc();
      cyc();
      chk_b("dir_rerr_sticky", range_error, 1'b1);
      chk_n("dir_done_stored", int'(num_stored), 3);
      cyc(0, 0, '0, 1);
      chk_b("restart_done", done, 1'b0);
      chk_b("restart_busy", busy, 1'b1);
      chk_b("restart_rerr", range_error, 1'b0);
      chk_n("restart_stored", int'(num_stored), 0);

      for (int r = 0; r < 6; r++) run_random();

      reset_test();

      repeat (3) cyc();
      chk_n("rd_pending", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
